// File: rtl/xactpool_pkg.sv
// ============================================================================
// Module  : xactpool_pkg
// Brief   : Bus geometry, configuration layout and FSM encoding for xactpool.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xactpool_pkg;

    localparam int N_WORDS    = 8;
    localparam int N_W        = 4;
    localparam int MEM_ADDR_W = 10;
    localparam int PERIOD_W   = 5;
    localparam int CONF_BITS  = N_W + MEM_ADDR_W + 2*PERIOD_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        POOL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Field order matches configdata, MSB first.
    typedef struct packed {
        logic [N_W-1:0]        sel;
        logic [MEM_ADDR_W-1:0] iterations;
        logic [PERIOD_W-1:0]   window;
        logic [PERIOD_W-1:0]   delay;
        logic                  relu;
    } conf_t;

endpackage

`default_nettype wire

// File: rtl/xactpool_xinmux.sv
// ============================================================================
// Module  : xinmux
// Brief   : Selects one DATA_W word out of the 2x data bus; word k sits at bits [k*DATA_W +: DATA_W].
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xinmux #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) (
    input  logic [N_W-1:0]              sel_i,
    input  logic [(2**N_W)*DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]           data_o
);

    logic [DATA_W-1:0] words [2**N_W];

    for (genvar k = 0; k < 2**N_W; k++) begin : g_word
        assign words[k] = data_i[k*DATA_W +: DATA_W];
    end

    assign data_o = words[sel_i];

endmodule

`default_nettype wire

// File: rtl/xactpool.sv
// ============================================================================
// Module  : xactpool
// Brief   : Max-pooling unit with optional ReLU; the clamp exists only when XACTPOOL_RELU_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xactpool
    import xactpool_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [2*N_WORDS*DATA_W-1:0]   flow_in,
    output logic [DATA_W-1:0]             flow_out,
    output logic                          done,
    input  logic [CONF_BITS-1:0]          configdata
);

    conf_t                 cfg;
    logic [DATA_W-1:0]     op;
    logic [PERIOD_W-1:0]   win_last;
    logic [PERIOD_W-1:0]   dly_last;
    logic [MEM_ADDR_W-1:0] iter_last;
    logic                  cfg_empty;
    logic                  wlast;
    logic [DATA_W-1:0]     pooled_d;
    logic [DATA_W-1:0]     out_d;

    state_t                state_q;
    logic [PERIOD_W-1:0]   dcnt_q;
    logic [PERIOD_W-1:0]   wcnt_q;
    logic [MEM_ADDR_W-1:0] icnt_q;
    logic [MEM_ADDR_W-1:0] ocnt_q;
    logic [DATA_W-1:0]     op_q;
    logic                  first_q;
    logic                  last_q;
    logic                  vld_q;
    logic [DATA_W-1:0]     acc_q;
    logic [DATA_W-1:0]     flow_out_q;
    logic                  done_q;

    assign cfg       = conf_t'(configdata);
    assign win_last  = cfg.window - PERIOD_W'(1);
    assign dly_last  = cfg.delay - PERIOD_W'(2);
    assign iter_last = cfg.iterations - MEM_ADDR_W'(1);
    assign cfg_empty = (cfg.iterations == '0) || (cfg.window == '0);
    assign wlast     = (wcnt_q == win_last);

    xinmux #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_xinmux (
        .sel_i  (cfg.sel),
        .data_i (flow_in),
        .data_o (op)
    );

    // Ties keep the accumulator.
    assign pooled_d = (first_q || ($signed(op_q) > $signed(acc_q))) ? op_q : acc_q;

`ifdef XACTPOOL_RELU_EN
    assign out_d = (cfg.relu && pooled_d[DATA_W-1]) ? '0 : pooled_d;
`else
    logic unused_relu;
    assign unused_relu = cfg.relu;
    assign out_d       = pooled_d;
`endif

    // The first sample is taken max(delay,1) cycles after the run pulse,
    // so the run cycle itself counts as one delay cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dcnt_q     <= '0;
            wcnt_q     <= '0;
            icnt_q     <= '0;
            ocnt_q     <= '0;
            op_q       <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            vld_q      <= 1'b0;
            acc_q      <= '0;
            flow_out_q <= '0;
            done_q     <= 1'b0;
        end else if (run) begin
            vld_q  <= 1'b0;
            dcnt_q <= '0;
            wcnt_q <= '0;
            icnt_q <= '0;
            ocnt_q <= '0;
            if (cfg_empty) begin
                state_q <= DONE;
                done_q  <= 1'b1;
            end else begin
                state_q <= (cfg.delay <= PERIOD_W'(1)) ? POOL : WAIT;
                done_q  <= 1'b0;
            end
        end else begin
            vld_q <= 1'b0;
            if (vld_q) begin
                acc_q <= pooled_d;
                if (last_q) begin
                    flow_out_q <= out_d;
                    if (ocnt_q == iter_last) begin
                        done_q <= 1'b1;
                    end else begin
                        ocnt_q <= ocnt_q + 1'b1;
                    end
                end
            end
            case (state_q)
                WAIT: begin
                    dcnt_q <= dcnt_q + 1'b1;
                    if (dcnt_q == dly_last) begin
                        state_q <= POOL;
                    end
                end
                POOL: begin
                    op_q    <= op;
                    first_q <= (wcnt_q == '0);
                    last_q  <= wlast;
                    vld_q   <= 1'b1;
                    if (wlast) begin
                        wcnt_q <= '0;
                        if (icnt_q == iter_last) begin
                            state_q <= DONE;
                        end else begin
                            icnt_q <= icnt_q + 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flow_out = flow_out_q;
    assign done     = done_q;

endmodule

`default_nettype wire
